rep_seq_checker: RTL

Synthesizable protocol checker that enforces the sequence "start, then exactly REP_N non-consecutive strobe beats, then a completion" in hardware. It is the on-chip counterpart of the team's simulation-only assertions for the a/b/c handshake. It tracks one attempt at a time and reports each outcome as a single-cycle pass or fail pulse. It also keeps saturating pass, fail and dropped-start counters for a debug/status register block.

---
 rtl/rep_seq_checker.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rep_seq_checker.sv
// Hardware checker for "a, then exactly REP_N b beats, then c" with a timeout,
// single-cycle pass/fail pulses and saturating pass/fail/dropped-start counters.
module rep_seq_checker #(
  parameter int REP_N   = 3,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         clr,
  input  logic                         a,
  input  logic                         b,
  input  logic                         c,
  output logic                         busy,
  output logic [$clog2(REP_N+1)-1:0]   b_count,
  output logic                         pass,
  output logic                         fail,
  output logic [1:0]                   fail_code,
  output logic [CNT_W-1:0]             pass_cnt,
  output logic [CNT_W-1:0]             fail_cnt,
  output logic [CNT_W-1:0]             drop_cnt
);

  localparam int BW = $clog2(REP_N + 1);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] COUNT  = 2'd1;
  localparam logic [1:0] WAIT_C = 2'd2;

  localparam logic [1:0] CODE_EXTRA_B = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;

  logic [1:0]    state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [BW-1:0] cnt_nx;
  logic          pass_nx, fail_nx;
  logic [1:0]    code_nx;
  logic          timer_last;
  logic          drop;

  assign timer_last = (timer == TW'(TIMEOUT - 1));
  assign drop       = a && (state != IDLE);

  // Next-state decision; within a cycle pass beats extra-b, which beats timeout.
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    cnt_nx   = b_count;
    pass_nx  = 1'b0;
    fail_nx  = 1'b0;
    code_nx  = fail_code;
    case (state)
      IDLE: begin
        if (en && a) begin
          state_nx = COUNT;
          cnt_nx   = '0;
          timer_nx = '0;
        end
      end
      COUNT: begin
        timer_nx = timer + TW'(1);
        if (b) cnt_nx = b_count + BW'(1);
        if (timer_last) begin
          state_nx = IDLE;
          fail_nx  = 1'b1;
          code_nx  = CODE_TIMEOUT;
          timer_nx = '0;
        end else if (b && (b_count == BW'(REP_N - 1))) begin
          state_nx = WAIT_C;
        end
      end
      WAIT_C: begin
        timer_nx = timer + TW'(1);
        if (c) begin
          state_nx = IDLE;
          pass_nx  = 1'b1;
          timer_nx = '0;
        end else if (b) begin
          state_nx = IDLE;
          fail_nx  = 1'b1;
          code_nx  = CODE_EXTRA_B;
          timer_nx = '0;
        end else if (timer_last) begin
          state_nx = IDLE;
          fail_nx  = 1'b1;
          code_nx  = CODE_TIMEOUT;
          timer_nx = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        timer_nx = '0;
      end
    endcase
    // Disabling the checker silently abandons whatever attempt is running.
    if ((state != IDLE) && !en) begin
      state_nx = IDLE;
      timer_nx = '0;
      cnt_nx   = '0;
      pass_nx  = 1'b0;
      fail_nx  = 1'b0;
      code_nx  = fail_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      b_count   <= '0;
      busy      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= 2'b00;
    end else begin
      state     <= state_nx;
      timer     <= timer_nx;
      b_count   <= cnt_nx;
      busy      <= (state_nx != IDLE);
      pass      <= pass_nx;
      fail      <= fail_nx;
      fail_code <= code_nx;
    end
  end

  // Statistics counters saturate at all-ones; clr wins over a same-cycle bump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      drop_cnt <= '0;
    end else if (clr) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (pass_nx && (pass_cnt != '1)) pass_cnt <= pass_cnt + CNT_W'(1);
      if (fail_nx && (fail_cnt != '1)) fail_cnt <= fail_cnt + CNT_W'(1);
      if (drop && (drop_cnt != '1))    drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule
